// File: rtl/jml_i2c_regs_pkg.sv
// Shared address map, control bit positions and pop/rewind FSM states for the
// I2C slave register/trace back end.
package jml_i2c_pkg;

  localparam logic [5:0] CTRL_BASE  = 6'h00;
  localparam logic [5:0] STAT_BASE  = 6'h08;
  localparam logic [5:0] ID_ADDR    = 6'h10;
  localparam logic [5:0] TSTAT_ADDR = 6'h11;
  localparam logic [5:0] TCNT_ADDR  = 6'h12;
  localparam logic [5:0] TRACE_BASE = 6'h30;

  localparam int unsigned ARM_BIT = 0;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    FALL
  } pop_state_t;

endpackage

// File: rtl/jml_sync_edge.sv
// N-stage synchroniser for a slow-domain level, with one-clk rise/fall pulses
// derived from the synchronised output.
module jml_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // All stages and the edge history come out of reset at RST_VAL, so a level
  // already at RST_VAL when reset releases produces no edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule

// File: rtl/jml_i2c_regs.sv
// Register file, trace buffer and pop/rewind sequencing behind the I2C slave
// bridge; all bridge strobes are synchronised into clk before use.
module jml_i2c_regs
  import jml_i2c_pkg::*;
#(
  parameter int unsigned TRACE_DEPTH = 64,
  parameter logic [7:0]  ID_VALUE    = 8'hA5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         scl,
  input  logic [5:0]                   addr,
  input  logic                         read,
  input  logic                         write,
  input  logic [7:0]                   write_data,
  output logic [7:0]                   read_data,
  input  logic                         rd_pop,
  input  logic                         trace_rd_reset,
  input  logic [63:0]                  stat_in,
  output logic [63:0]                  ctrl_regs,
  output logic                         ctrl_wr_stb,
  output logic [2:0]                   ctrl_wr_addr,
  input  logic                         trace_wr,
  input  logic [7:0]                   trace_din,
  output logic                         trace_full,
  output logic [$clog2(TRACE_DEPTH):0] trace_cnt
);

  localparam int unsigned AW = $clog2(TRACE_DEPTH);

  logic scl_s, scl_rise, write_rise, rd_pop_s, trst_s;
  logic unused_scl_fall, unused_write_s, unused_write_fall;
  logic unused_pop_rise, unused_pop_fall, unused_trst_rise, unused_trst_fall;
  logic unused_read;

  assign unused_read = read;

  // scl resets high so a reset released mid-pulse cannot fake a rising edge.
  jml_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_scl (
    .clk(clk), .rst_n(reset_n), .d(scl),
    .q(scl_s), .rise(scl_rise), .fall(unused_scl_fall)
  );
  jml_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_write (
    .clk(clk), .rst_n(reset_n), .d(write),
    .q(unused_write_s), .rise(write_rise), .fall(unused_write_fall)
  );
  jml_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_pop (
    .clk(clk), .rst_n(reset_n), .d(rd_pop),
    .q(rd_pop_s), .rise(unused_pop_rise), .fall(unused_pop_fall)
  );
  jml_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_trst (
    .clk(clk), .rst_n(reset_n), .d(trace_rd_reset),
    .q(trst_s), .rise(unused_trst_rise), .fall(unused_trst_fall)
  );

  logic [63:0] ctrl_q, ctrl_d;
  logic        stb_q, stb_d;
  logic [2:0]  wr_addr_q, wr_addr_d;
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q;
  logic [7:0]  rdata_q, rdata_d;
  logic [7:0]  mem_q [TRACE_DEPTH];
  pop_state_t  state_q;
  logic        pend_pop_q, pend_rst_q;
  logic        arm, full, capture;
  logic [7:0]  cnt_byte;

  assign arm      = ctrl_q[8*7 + ARM_BIT];
  // Depth is a power of two and the pointer never passes it, so the MSB is full.
  assign full     = wptr_q[AW];
  assign capture  = trace_wr & arm & ~full;
  assign cnt_byte = 8'(wptr_q);

  always_comb begin
    ctrl_d    = ctrl_q;
    stb_d     = 1'b0;
    wr_addr_d = wr_addr_q;
    wptr_d    = wptr_q;
    if (capture) wptr_d = wptr_q + 1'b1;
    if (write_rise && addr[5:3] == CTRL_BASE[5:3]) begin
      ctrl_d[{addr[2:0], 3'b000} +: 8] = write_data;
      stb_d     = 1'b1;
      wr_addr_d = addr[2:0];
      if (addr[2:0] == 3'd7 && write_data[ARM_BIT] && !arm) wptr_d = '0;
    end
  end

  always_comb begin
    rdata_d = '0;
    if (addr[5:3] == CTRL_BASE[5:3])       rdata_d = ctrl_q[{addr[2:0], 3'b000} +: 8];
    else if (addr[5:3] == STAT_BASE[5:3])  rdata_d = stat_in[{addr[2:0], 3'b000} +: 8];
    else if (addr == ID_ADDR)              rdata_d = ID_VALUE;
    else if (addr == TSTAT_ADDR)           rdata_d = {6'b0, full, arm};
    else if (addr == TCNT_ADDR)            rdata_d = cnt_byte;
    else if (addr[5:4] == TRACE_BASE[5:4]) rdata_d = (rptr_q < wptr_q) ? mem_q[rptr_q[AW-1:0]] : 8'h00;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q    <= '0;
      stb_q     <= 1'b0;
      wr_addr_q <= '0;
      wptr_q    <= '0;
      rdata_q   <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      stb_q     <= stb_d;
      wr_addr_q <= wr_addr_d;
      wptr_q    <= wptr_d;
      rdata_q   <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) mem_q[wptr_q[AW-1:0]] <= trace_din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pend_pop_q <= 1'b0;
      pend_rst_q <= 1'b0;
      rptr_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (scl_rise) state_q <= HIGH;
        HIGH: begin
          if (scl_s) begin
            pend_pop_q <= pend_pop_q | rd_pop_s;
            pend_rst_q <= pend_rst_q | trst_s;
          end else begin
            state_q <= FALL;
          end
        end
        FALL: begin
          if (pend_rst_q)                       rptr_q <= '0;
          else if (pend_pop_q && rptr_q < wptr_q) rptr_q <= rptr_q + 1'b1;
          pend_pop_q <= 1'b0;
          pend_rst_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign read_data    = rdata_q;
  assign ctrl_regs    = ctrl_q;
  assign ctrl_wr_stb  = stb_q;
  assign ctrl_wr_addr = wr_addr_q;
  assign trace_full   = full;
  assign trace_cnt    = wptr_q;

endmodule

// File: tb/tb_jml_i2c_regs.sv
// Directed bench for jml_i2c_regs: control writes, trace capture/pop/rewind,
// fill saturation, ignored writes and reset in the middle of an scl pulse.
module tb_jml_i2c_regs;

  localparam int unsigned DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        scl = 1'b0;
  logic [5:0]  addr = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [7:0]  write_data = '0;
  logic [7:0]  read_data;
  logic        rd_pop = 1'b0;
  logic        trace_rd_reset = 1'b0;
  logic [63:0] stat_in = '0;
  logic [63:0] ctrl_regs;
  logic        ctrl_wr_stb;
  logic [2:0]  ctrl_wr_addr;
  logic        trace_wr = 1'b0;
  logic [7:0]  trace_din = '0;
  logic        trace_full;
  logic [6:0]  trace_cnt;

  int          checks = 0;
  int          errors = 0;
  int          stb_cnt = 0;
  logic [2:0]  stb_addr = '0;

  jml_i2c_regs #(.TRACE_DEPTH(DEPTH), .ID_VALUE(8'hA5), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .scl(scl), .addr(addr), .read(read),
    .write(write), .write_data(write_data), .read_data(read_data),
    .rd_pop(rd_pop), .trace_rd_reset(trace_rd_reset), .stat_in(stat_in),
    .ctrl_regs(ctrl_regs), .ctrl_wr_stb(ctrl_wr_stb), .ctrl_wr_addr(ctrl_wr_addr),
    .trace_wr(trace_wr), .trace_din(trace_din), .trace_full(trace_full),
    .trace_cnt(trace_cnt)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (ctrl_wr_stb) begin
      stb_cnt++;
      stb_addr = ctrl_wr_addr;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One full scl period (~125 clk at 50 MHz / 400 kHz) with pop/rewind levels.
  task automatic scl_pulse(input logic pop, input logic rst);
    @(negedge clk);
    scl = 1'b1; rd_pop = pop; trace_rd_reset = rst;
    wait_clk(62);
    scl = 1'b0; rd_pop = 1'b0; trace_rd_reset = 1'b0;
    wait_clk(63);
  endtask

  task automatic bridge_write(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; write_data = d; write = 1'b1;
    scl_pulse(1'b0, 1'b0);
    write = 1'b0;
    wait_clk(4);
  endtask

  task automatic capture(input logic [7:0] b);
    @(negedge clk);
    trace_wr = 1'b1; trace_din = b;
    @(negedge clk);
    trace_wr = 1'b0;
  endtask

  task automatic set_addr(input logic [5:0] a);
    @(negedge clk);
    addr = a;
    wait_clk(3);
  endtask

  task automatic test_reset;
    wait_clk(3);
    reset_n = 1'b1;
    wait_clk(3);
    checks++; if (ctrl_regs !== 64'h0) begin errors++; $display("FAIL reset_ctrl: got %h expected %h", ctrl_regs, 64'h0); end
    checks++; if (read_data !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h expected %h", read_data, 8'h00); end
    checks++; if (ctrl_wr_stb !== 1'b0 || ctrl_wr_addr !== 3'd0) begin errors++; $display("FAIL reset_stb: got %b/%0d expected 0/0", ctrl_wr_stb, ctrl_wr_addr); end
    checks++; if (trace_full !== 1'b0 || trace_cnt !== 7'd0) begin errors++; $display("FAIL reset_trace: got full=%b cnt=%0d expected 0/0", trace_full, trace_cnt); end
  endtask

  task automatic test_ctrl_write;
    int s0;
    s0 = stb_cnt;
    bridge_write(6'h03, 8'h5C);
    checks++; if (ctrl_regs !== 64'h0000_0000_5C00_0000) begin errors++; $display("FAIL ctrl_write: got %h expected %h", ctrl_regs, 64'h0000_0000_5C00_0000); end
    checks++; if (stb_cnt - s0 !== 1) begin errors++; $display("FAIL ctrl_stb_count: got %0d expected 1", stb_cnt - s0); end
    checks++; if (stb_addr !== 3'd3) begin errors++; $display("FAIL ctrl_stb_addr: got %0d expected 3", stb_addr); end
    set_addr(6'h03);
    checks++; if (read_data !== 8'h5C) begin errors++; $display("FAIL ctrl_readback: got %h expected %h", read_data, 8'h5C); end
  endtask

  task automatic test_trace_pop;
    bridge_write(6'h07, 8'h01);
    capture(8'h11); capture(8'h22); capture(8'h33);
    set_addr(6'h30);
    checks++; if (read_data !== 8'h11) begin errors++; $display("FAIL pop0_data: got %h expected %h", read_data, 8'h11); end
    scl_pulse(1'b1, 1'b0);
    checks++; if (read_data !== 8'h22) begin errors++; $display("FAIL pop1_data: got %h expected %h", read_data, 8'h22); end
    scl_pulse(1'b1, 1'b0);
    checks++; if (read_data !== 8'h33) begin errors++; $display("FAIL pop2_data: got %h expected %h", read_data, 8'h33); end
    scl_pulse(1'b1, 1'b0);
    checks++; if (read_data !== 8'h00) begin errors++; $display("FAIL pop3_empty: got %h expected %h", read_data, 8'h00); end
    checks++; if (trace_cnt !== 7'd3) begin errors++; $display("FAIL pop3_cnt: got %0d expected 3", trace_cnt); end
    // extra pop at the write pointer must not advance past it
    scl_pulse(1'b1, 1'b0);
    capture(8'h44);
    wait_clk(3);
    checks++; if (read_data !== 8'h44) begin errors++; $display("FAIL pop_saturate: got %h expected %h", read_data, 8'h44); end
  endtask

  task automatic test_rewind;
    scl_pulse(1'b0, 1'b1);
    checks++; if (read_data !== 8'h11) begin errors++; $display("FAIL rewind_data: got %h expected %h", read_data, 8'h11); end
    for (int i = 0; i < 4; i++) scl_pulse(1'b1, 1'b0);
    checks++; if (read_data !== 8'h00) begin errors++; $display("FAIL four_pops_end: got %h expected %h", read_data, 8'h00); end
    scl_pulse(1'b1, 1'b1);
    checks++; if (read_data !== 8'h11) begin errors++; $display("FAIL rewind_wins: got %h expected %h", read_data, 8'h11); end
  endtask

  task automatic test_fill;
    bridge_write(6'h07, 8'h00);
    bridge_write(6'h07, 8'h01);
    checks++; if (trace_cnt !== 7'd0 || trace_full !== 1'b0) begin errors++; $display("FAIL rearm_clear: got cnt=%0d full=%b expected 0/0", trace_cnt, trace_full); end
    for (int i = 0; i < DEPTH + 5; i++) capture(8'(i * 3 + 1));
    wait_clk(2);
    checks++; if (trace_full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b expected 1", trace_full); end
    checks++; if (trace_cnt !== 7'd64) begin errors++; $display("FAIL fill_cnt: got %0d expected 64", trace_cnt); end
    set_addr(6'h11);
    checks++; if (read_data !== 8'h03) begin errors++; $display("FAIL fill_tstat: got %h expected %h", read_data, 8'h03); end
    set_addr(6'h12);
    checks++; if (read_data !== 8'h40) begin errors++; $display("FAIL fill_tcnt: got %h expected %h", read_data, 8'h40); end
    set_addr(6'h30);
    scl_pulse(1'b0, 1'b1);
    checks++; if (read_data !== 8'h01) begin errors++; $display("FAIL fill_first: got %h expected %h", read_data, 8'h01); end
    for (int i = 0; i < DEPTH - 1; i++) scl_pulse(1'b1, 1'b0);
    checks++; if (read_data !== 8'hBE) begin errors++; $display("FAIL fill_last: got %h expected %h", read_data, 8'hBE); end
    scl_pulse(1'b1, 1'b0);
    checks++; if (read_data !== 8'h00) begin errors++; $display("FAIL fill_dropped: got %h expected %h", read_data, 8'h00); end
  endtask

  task automatic test_ignored_writes;
    int s0;
    s0 = stb_cnt;
    bridge_write(6'h10, 8'hFF);
    bridge_write(6'h20, 8'h77);
    checks++; if (ctrl_regs !== 64'h0100_0000_5C00_0000) begin errors++; $display("FAIL ignored_ctrl: got %h expected %h", ctrl_regs, 64'h0100_0000_5C00_0000); end
    checks++; if (stb_cnt !== s0) begin errors++; $display("FAIL ignored_stb: got %0d expected %0d", stb_cnt, s0); end
    set_addr(6'h10);
    checks++; if (read_data !== 8'hA5) begin errors++; $display("FAIL id_read: got %h expected %h", read_data, 8'hA5); end
    stat_in = 64'h8877_6655_4433_2211;
    set_addr(6'h0B);
    checks++; if (read_data !== 8'h44) begin errors++; $display("FAIL stat_read: got %h expected %h", read_data, 8'h44); end
    set_addr(6'h13);
    checks++; if (read_data !== 8'h00) begin errors++; $display("FAIL unmapped_read: got %h expected %h", read_data, 8'h00); end
  endtask

  task automatic test_reset_mid;
    set_addr(6'h30);
    @(negedge clk);
    scl = 1'b1; rd_pop = 1'b1;
    wait_clk(20);
    reset_n = 1'b0;
    #3;
    checks++; if (ctrl_regs !== 64'h0 || read_data !== 8'h00) begin errors++; $display("FAIL midrst_regs: got ctrl=%h rdata=%h expected 0/0", ctrl_regs, read_data); end
    checks++; if (ctrl_wr_addr !== 3'd0 || ctrl_wr_stb !== 1'b0) begin errors++; $display("FAIL midrst_stb: got %b/%0d expected 0/0", ctrl_wr_stb, ctrl_wr_addr); end
    checks++; if (trace_full !== 1'b0 || trace_cnt !== 7'd0) begin errors++; $display("FAIL midrst_trace: got full=%b cnt=%0d expected 0/0", trace_full, trace_cnt); end
    wait_clk(2);
    reset_n = 1'b1;
    wait_clk(5);
    addr = 6'h07; write_data = 8'h01; write = 1'b1;
    wait_clk(6);
    write = 1'b0;
    wait_clk(2);
    capture(8'h21); capture(8'h43);
    addr = 6'h30;
    wait_clk(4);
    scl = 1'b0; rd_pop = 1'b0;
    wait_clk(63);
    checks++; if (read_data !== 8'h21) begin errors++; $display("FAIL midrst_no_pop: got %h expected %h", read_data, 8'h21); end
    scl_pulse(1'b1, 1'b0);
    checks++; if (read_data !== 8'h43) begin errors++; $display("FAIL midrst_next_pop: got %h expected %h", read_data, 8'h43); end
  endtask

  initial begin
    test_reset();
    test_ctrl_write();
    test_trace_pop();
    test_rewind();
    test_fill();
    test_ignored_writes();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jml_i2c_regs.md
Name: jml_i2c_regs

Overview:
Register/trace back end for the I2C slave bridge, in the system clock domain. Consumes the bridge strobes (addr, write, write_data, rd_pop, trace_rd_reset), which are generated on falling scl, and synchronises them to clk. Owns 8 RW control registers, 8 RO status registers, a constant ID byte and a TRACE_DEPTH x 8 trace buffer. Returns read_data to the bridge for the currently addressed location.

Parameters:
TRACE_DEPTH, 64, trace buffer entries; power of 2, range 16..256
ID_VALUE, 8'hA5, constant returned at address 0x10
SYNC_STAGES, 2, synchroniser flops on each scl-domain input

Ports:
clk  in  1  system clock; must be >= 8x the scl frequency
reset_n  in  1  asynchronous active-low reset
scl  in  1  raw I2C clock; used only to qualify strobes
addr  in  6  bridge logical address (scl domain)
read  in  1  bridge read-in-progress flag; debug/status only
write  in  1  bridge write strobe; registered, one scl period wide
write_data  in  8  bridge write byte; stable while write is high
read_data  out  8  data for addr, to the bridge
rd_pop  in  1  bridge trace-advance request; level-valid while scl is high
trace_rd_reset  in  1  bridge trace-rewind request; level-valid while scl is high
stat_in  in  64  status bytes for 0x08..0x0F; byte n = stat_in[8n+7:8n]
ctrl_regs  out  64  control bytes for 0x00..0x07, same packing
ctrl_wr_stb  out  1  one-clk pulse after any control register write
ctrl_wr_addr  out  3  index of the register written; valid with ctrl_wr_stb
trace_wr  in  1  capture strobe for trace_din
trace_din  in  8  capture byte
trace_full  out  1  write pointer has reached TRACE_DEPTH
trace_cnt  out  $clog2(TRACE_DEPTH)+1  number of entries captured

Behaviour:
- Reset values: ctrl_regs=0, read_data=0, ctrl_wr_stb=0, ctrl_wr_addr=0, trace_full=0, trace_cnt=0. Write pointer and read pointer are 0.
- Synchronisers: scl, write, rd_pop and trace_rd_reset each pass through SYNC_STAGES flops. addr and write_data are not synchronised. They are sampled only when write_s rises, at which point they have been stable for more than 2 clk.
- Write: on the 0->1 edge of write_s, latch addr and write_data.
  - 0x00..0x07: update ctrl_regs byte. Next clk: ctrl_wr_stb=1, ctrl_wr_addr=addr[2:0]. Latency from write_s rise to ctrl_regs update is 1 clk.
  - All other addresses: the write is ignored and no strobe is issued.
- Control register 0x07 bit 0 is ARM. A write that takes ARM from 0 to 1 clears the write pointer, trace_cnt and trace_full.
- Pop/rewind state machine, states IDLE -> HIGH -> FALL:
  - IDLE: wait for scl_s=1, then go to HIGH.
  - HIGH: OR-accumulate rd_pop_s into pend_pop and trace_rd_reset_s into pend_rst. Go to FALL when scl_s=0.
  - FALL: for one clk, apply pend_rst (read pointer to 0) or, if pend_rst is clear, pend_pop (read pointer +1). Clear both flags, then go to IDLE.
  - Exactly one action per scl pulse. If pend_rst and pend_pop are both set, rewind wins.
- Read pointer saturates at the write pointer; a pop at the write pointer is a no-op. The pointer does not wrap.
- A bridge write to 0x3x can raise rd_pop. It is honoured like any other pop.
- Capture: when trace_wr=1, ARM=1 and trace_full=0, write trace_din at the write pointer and increment trace_cnt. trace_full=1 when trace_cnt==TRACE_DEPTH. Further trace_wr is dropped; there is no wrap.
- Simultaneous capture and pop in the same clk are independent.
- Read mux, read_data registered (1 clk after addr or data change):
  - 0x00..0x07: ctrl byte
  - 0x08..0x0F: stat byte
  - 0x10: ID_VALUE
  - 0x11: {6'b0, trace_full, ARM}
  - 0x12: trace_cnt[7:0]
  - 0x30..0x3F: mem[read pointer], or 0x00 if read pointer == write pointer
  - all others: 0x00
- Timing: read_data must settle within one scl period of an addr change. This is guaranteed by clk >= 8x scl and 1-clk mux latency.
- Reset mid-transaction: all state clears asynchronously, and any pending pop or rewind is discarded. After reset the first action requires a complete scl high/low pulse to be observed.

Decomposition:
- Package jml_i2c_pkg holds:
  - address map constants: CTRL_BASE=6'h00, STAT_BASE=6'h08, ID_ADDR=6'h10, TSTAT_ADDR=6'h11, TCNT_ADDR=6'h12, TRACE_BASE=6'h30
  - ARM_BIT=0
  - enum pop_state_t {IDLE, HIGH, FALL}
- Sub-module jml_sync_edge: an N-stage synchroniser with rise and fall pulse outputs. It is instantiated for scl, write, rd_pop and trace_rd_reset.

Test Plan:
- Write 0x5C to addr 0x03 with write held one scl period (scl 400 kHz, clk 50 MHz) -> ctrl_regs[31:24]=0x5C; one ctrl_wr_stb with ctrl_wr_addr=3; all other bytes 0.
- Arm (0x07<=0x01), capture 0x11,0x22,0x33, set addr=0x30, issue 2 pops -> read_data 0x11, then 0x22, then 0x33; a third pop leaves read_data=0x00 and trace_cnt=3.
- Fill TRACE_DEPTH+5 captures -> trace_full=1, trace_cnt=TRACE_DEPTH, addr 0x11 reads 0x03, last 5 bytes dropped.
- rd_pop and trace_rd_reset both high in one scl-high window after 4 pops -> read pointer=0, read_data=first entry.
- Write to 0x10 and 0x20 -> ID still reads 0xA5; no ctrl_wr_stb.
- Assert reset_n low between scl rise and fall with rd_pop high -> after release no pop occurs and read pointer=0; all outputs at reset values.
